// File: rtl/ballot_assembler_if.sv
// Vote/RNG inputs and ballot handshake between the vote processor, the RNG
// and the encryption stage.
interface ballot_assembler_if #(
  parameter int RAND_WIDTH  = 32,
  parameter int NONCE_WORDS = 4,
  parameter int COUNT_WIDTH = 16
);
  logic                              vote_in;
  logic                              vote_valid_in;
  logic [RAND_WIDTH-1:0]             rand_in;
  logic                              rand_valid_in;
  logic [NONCE_WORDS*RAND_WIDTH:0]   ballot_out;
  logic                              ballot_valid_out;
  logic                              ballot_ready_in;
  logic                              busy_out;
  logic                              dropped_out;
  logic [COUNT_WIDTH-1:0]            accepted_count_out;

  modport slave (
    input  vote_in, vote_valid_in, rand_in, rand_valid_in, ballot_ready_in,
    output ballot_out, ballot_valid_out, busy_out, dropped_out, accepted_count_out
  );

  modport master (
    output vote_in, vote_valid_in, rand_in, rand_valid_in, ballot_ready_in,
    input  ballot_out, ballot_valid_out, busy_out, dropped_out, accepted_count_out
  );
endinterface

// File: rtl/ballot_assembler.sv
// Pairs each accepted vote with a nonce gathered from NONCE_WORDS RNG blocks
// and presents {nonce, vote} over valid/ready; counts delivered ballots.
module ballot_assembler #(
  parameter int RAND_WIDTH  = 32,
  parameter int NONCE_WORDS = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ballot_assembler_if.slave  bus
);
  localparam int NW  = NONCE_WORDS * RAND_WIDTH;
  localparam int WCW = $clog2(NONCE_WORDS + 1);

  typedef enum logic [1:0] {IDLE, GATHER, PRESENT} state_t;

  state_t                 state;
  logic [NW-1:0]          nonce;
  logic [NW-1:0]          nonce_next;
  logic                   vote;
  logic [WCW-1:0]         word_cnt;
  logic                   ballot_valid;
  logic                   busy;
  logic                   dropped;
  logic [COUNT_WIDTH-1:0] count;

  // New block enters at the top so the first block ends up least significant.
  generate
    if (NONCE_WORDS == 1) begin : g_one
      assign nonce_next = bus.rand_in;
    end else begin : g_many
      assign nonce_next = {bus.rand_in, nonce[NW-1:RAND_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      nonce        <= '0;
      vote         <= 1'b0;
      word_cnt     <= '0;
      ballot_valid <= 1'b0;
      busy         <= 1'b0;
      dropped      <= 1'b0;
      count        <= '0;
    end else begin
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.vote_valid_in) begin
            vote     <= bus.vote_in;
            word_cnt <= '0;
            nonce    <= '0;
            busy     <= 1'b1;
            state    <= GATHER;
          end
        end
        GATHER: begin
          if (bus.vote_valid_in) dropped <= 1'b1;
          if (bus.rand_valid_in) begin
            nonce    <= nonce_next;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == WCW'(NONCE_WORDS - 1)) begin
              ballot_valid <= 1'b1;
              state        <= PRESENT;
            end
          end
        end
        PRESENT: begin
          // A strobe on the handshake cycle is still dropped; only IDLE accepts.
          if (bus.vote_valid_in) dropped <= 1'b1;
          if (bus.ballot_ready_in) begin
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
            if (count != '1) count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ballot_out         = {nonce, vote};
  assign bus.ballot_valid_out   = ballot_valid;
  assign bus.busy_out           = busy;
  assign bus.dropped_out        = dropped;
  assign bus.accepted_count_out = count;
endmodule

// File: doc/ballot_assembler.md
# ballot_assembler

Assembles one ballot per decoded vote by pairing the 1-bit candidate choice from the vote processor with a fresh nonce built from consecutive random-generator blocks. Sits directly downstream of the vote processor and the random generator, and presents a wide ballot word over a valid/ready handshake to the encryption stage. Also keeps a saturating count of ballots delivered.

## Interface
- RAND_WIDTH, 32, width of one random block from the RNG
- NONCE_WORDS, 4, number of random blocks per nonce (NONCE_WORDS ≥ 1)
- COUNT_WIDTH, 16, width of delivered-ballot counter
- clk_in  input  1  system clock; all logic in this single domain
- rst_in  input  1  asynchronous, active-low reset
- vote_in  input  1  candidate choice, qualified by vote_valid_in
- vote_valid_in  input  1  single-cycle strobe, vote_in valid
- rand_in  input  RAND_WIDTH  random block, qualified by rand_valid_in
- rand_valid_in  input  1  rand_in valid this cycle
- ballot_out  output  NONCE_WORDS*RAND_WIDTH+1  {nonce, vote}; vote is bit 0
- ballot_valid_out  output  1  ballot_out valid; held until accepted
- ballot_ready_in  input  1  downstream accepts when high with ballot_valid_out
- busy_out  output  1  high in GATHER or PRESENT
- dropped_out  output  1  one-cycle pulse when a vote strobe is ignored
- accepted_count_out  output  COUNT_WIDTH  ballots delivered, saturating

## Operation
- States: IDLE, GATHER, PRESENT.
- IDLE: on vote_valid_in, latch vote_in into vote register, clear word counter, clear nonce register, go to GATHER. rand_valid_in is ignored and the block is discarded.
- GATHER: each cycle rand_valid_in is high, nonce <= {rand_in, nonce[NONCE_WORDS*RAND_WIDTH-1:RAND_WIDTH]}. The first word received ends up in the least-significant nonce bits and the last word in the most-significant bits. The word counter increments. On the cycle the NONCE_WORDSth word is accepted, go to PRESENT. Cycles with rand_valid_in low do nothing.
- PRESENT: ballot_valid_out = 1, and ballot_out holds stable. rand_valid_in is ignored. On ballot_valid_out && ballot_ready_in, return to IDLE and increment accepted_count_out, saturating at 2^COUNT_WIDTH-1.
- ballot_out = {nonce_reg, vote_reg} at all times. It is meaningful only while ballot_valid_out is high and may change during GATHER.
- A vote_valid_in arriving in GATHER or PRESENT is ignored. dropped_out pulses high the next cycle. The in-progress vote and nonce are unaffected.
- This includes the handshake cycle of PRESENT: a vote arriving in that same cycle is dropped. A new vote is accepted only while in IDLE.
- busy_out = (state != IDLE).
- Each random block is consumed at most once; no block is reused across ballots.

## Timing
- Reset (rst_in low, asynchronous) applies the following. Releasing reset returns to normal operation on the next clock edge.
  - state = IDLE
  - ballot_valid_out = 0
  - busy_out = 0
  - dropped_out = 0
  - accepted_count_out = 0
  - nonce and vote registers = 0, so ballot_out = 0
- Reset during GATHER or PRESENT aborts the ballot. The ballot is never presented and the count is not incremented.
- Vote strobe in cycle T (IDLE): busy_out is high from T+1.
- With rand_valid_in high every cycle from T+1, the last word is taken at T+NONCE_WORDS and ballot_valid_out rises at T+NONCE_WORDS+1.
- Handshake in cycle H:
  - ballot_valid_out is low at H+1.
  - accepted_count_out shows the new value at H+1.
  - busy_out is low at H+1.
  - The earliest next accepted vote is at H+1.
- With ballot_ready_in held high, minimum ballot period is NONCE_WORDS+2 cycles.
- ballot_ready_in high while ballot_valid_out is low has no effect.
- dropped_out is registered and high for exactly one cycle per ignored strobe.

## Test plan
- Reset: hold rst_in low, drive all inputs to random values -> all outputs 0. Release reset -> state IDLE, no spurious ballot_valid_out.
- Nominal (RAND_WIDTH=32, NONCE_WORDS=4):
  - Stimulus: vote_in=1 strobed at cycle 10. Then 0x11111111, 0x22222222, 0x33333333, 0x44444444 on rand_in at cycles 11–14. ballot_ready_in held high.
  - Response: ballot_valid_out rises at cycle 15 with ballot_out = {0x44444444, 0x33333333, 0x22222222, 0x11111111, 1'b1}. Handshake at cycle 15; at cycle 16, accepted_count_out = 1 and busy_out = 0.
- Gaps and backpressure:
  - Stimulus: rand_valid_in high only every third cycle. ballot_ready_in low for 5 cycles after ballot_valid_out rises.
  - Response: exactly 4 words are consumed. ballot_out and ballot_valid_out stay constant for all 5 stall cycles. A single count increment occurs on the handshake.
- Drop:
  - Stimulus: vote_in=0 strobed; then vote_in=1 strobed after 2 words in GATHER; then another strobe on the handshake cycle.
  - Response: dropped_out pulses twice. The ballot has bit 0 = 0. Count increases by 1. Random blocks seen during IDLE and PRESENT are absent from the nonce.
- Abort: assert rst_in after 2 of 4 words -> immediate IDLE, count unchanged. The next vote's ballot contains only the 4 post-reset words.
- Saturation (COUNT_WIDTH=2): deliver 5 ballots -> accepted_count_out reads 1, 2, 3, 3, 3.
